// File: rtl/jml_i2c_master.sv
// I2C controller for register-bridge transfers: START, address/register/data
// bytes, optional repeated START and multi-byte read, STOP, on open-drain SCL/SDA.
module jml_i2c_master #(
  parameter int unsigned CLK_DIV = 125,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic [3:0] nbytes,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drv_lo,
  output logic       sda_drv_lo
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_DEVW, ST_REG, ST_WDATA, ST_RSTART, ST_DEVR, ST_RDATA, ST_STOP
  } state_t;

  state_t           r_state, w_nxt_state;
  logic [1:0]       r_q, w_nxt_q;
  logic [3:0]       r_bit, w_nxt_bit;
  logic [CNT_W-1:0] r_qcnt, w_nxt_qcnt;
  logic [3:0]       r_left, w_nxt_left;
  logic             r_rw, w_nxt_rw;
  logic [6:0]       r_dev, w_nxt_dev;
  logic [7:0]       r_reg, w_nxt_reg;
  logic [7:0]       r_wdata, w_nxt_wdata;
  logic [6:0]       r_shift, w_nxt_shift;
  logic             r_nack, w_nxt_nack;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;
  logic             r_ack_err, w_nxt_ack_err;
  logic [7:0]       r_rdata, w_nxt_rdata;
  logic             r_rdata_valid, w_nxt_rdata_valid;
  logic             r_scl_lo, w_nxt_scl_lo;
  logic             r_sda_lo, w_nxt_sda_lo;
  logic [7:0]       w_tx;
  logic             w_stall;
  logic             w_tick;

  // Pin drive {scl_lo, sda_lo} for a given phase/quarter/bit.
  function automatic logic [1:0] pins(input state_t st, input logic [1:0] q,
                                      input logic [3:0] bidx, input logic [7:0] tx,
                                      input logic last);
    case (st)
      ST_START:  pins = {1'b0, q[1]};
      ST_STOP:   pins = {q == 2'd0, !q[1]};
      ST_RSTART: pins = {(q == 2'd0) || (q == 2'd3), q[1]};
      ST_DEVW, ST_REG, ST_WDATA, ST_DEVR:
        pins = {!q[1], bidx[3] ? 1'b0 : !tx[3'd7 - bidx[2:0]]};
      ST_RDATA:  pins = {!q[1], bidx[3] ? !last : 1'b0};
      default:   pins = 2'b00;
    endcase
  endfunction

  // Q2 waits for the target to let SCL go high.
  assign w_stall = (r_q == 2'd2) && !scl_in;
  assign w_tick  = (r_qcnt == CNT_W'(CLK_DIV - 1)) && !w_stall;

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_q           = r_q;
    w_nxt_bit         = r_bit;
    w_nxt_qcnt        = r_qcnt;
    w_nxt_left        = r_left;
    w_nxt_rw          = r_rw;
    w_nxt_dev         = r_dev;
    w_nxt_reg         = r_reg;
    w_nxt_wdata       = r_wdata;
    w_nxt_shift       = r_shift;
    w_nxt_nack        = r_nack;
    w_nxt_busy        = r_busy;
    w_nxt_done        = 1'b0;
    w_nxt_ack_err     = r_ack_err;
    w_nxt_rdata       = r_rdata;
    w_nxt_rdata_valid = 1'b0;

    if (r_state == ST_IDLE) begin
      if (r_busy) begin
        w_nxt_busy = 1'b0;
      end else if (start) begin
        w_nxt_state   = ST_START;
        w_nxt_q       = 2'd0;
        w_nxt_bit     = 4'd0;
        w_nxt_qcnt    = '0;
        w_nxt_rw      = rw;
        w_nxt_dev     = dev_addr;
        w_nxt_reg     = reg_addr;
        w_nxt_wdata   = wdata;
        w_nxt_left    = (nbytes == 4'd0) ? 4'd1 : nbytes;
        w_nxt_nack    = 1'b0;
        w_nxt_ack_err = 1'b0;
        w_nxt_busy    = 1'b1;
      end
    end else begin
      if (w_tick) begin
        w_nxt_qcnt = '0;
      end else if (!w_stall) begin
        w_nxt_qcnt = r_qcnt + CNT_W'(1);
      end
      if (w_tick) begin
        if (r_q != 2'd3) begin
          w_nxt_q = r_q + 2'd1;
        end else begin
          // End of a bit period: advance the sequence.
          w_nxt_q = 2'd0;
          case (r_state)
            ST_START: begin
              w_nxt_state = ST_DEVW;
              w_nxt_bit   = 4'd0;
            end
            ST_DEVW, ST_REG, ST_WDATA, ST_DEVR: begin
              if (!r_bit[3]) begin
                w_nxt_bit = r_bit + 4'd1;
              end else begin
                w_nxt_bit = 4'd0;
                if (sda_in) begin
                  w_nxt_nack  = 1'b1;
                  w_nxt_state = ST_STOP;
                end else begin
                  case (r_state)
                    ST_DEVW: w_nxt_state = ST_REG;
                    ST_REG:  w_nxt_state = r_rw ? ST_RSTART : ST_WDATA;
                    ST_WDATA: w_nxt_state = ST_STOP;
                    default: w_nxt_state = ST_RDATA;
                  endcase
                end
              end
            end
            ST_RSTART: begin
              w_nxt_state = ST_DEVR;
              w_nxt_bit   = 4'd0;
            end
            ST_RDATA: begin
              if (!r_bit[3]) begin
                w_nxt_shift = {r_shift[5:0], sda_in};
                w_nxt_bit   = r_bit + 4'd1;
                if (r_bit == 4'd7) begin
                  w_nxt_rdata       = {r_shift, sda_in};
                  w_nxt_rdata_valid = 1'b1;
                end
              end else begin
                w_nxt_bit = 4'd0;
                if (r_left == 4'd1) begin
                  w_nxt_state = ST_STOP;
                end else begin
                  w_nxt_left = r_left - 4'd1;
                end
              end
            end
            ST_STOP: begin
              w_nxt_state   = ST_IDLE;
              w_nxt_done    = 1'b1;
              w_nxt_ack_err = r_nack;
            end
            default: w_nxt_state = ST_IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    w_tx = 8'h00;
    case (w_nxt_state)
      ST_DEVW:  w_tx = {r_dev, 1'b0};
      ST_REG:   w_tx = r_reg;
      ST_WDATA: w_tx = r_wdata;
      ST_DEVR:  w_tx = {r_dev, 1'b1};
      default:  w_tx = 8'h00;
    endcase
  end

  assign {w_nxt_scl_lo, w_nxt_sda_lo} =
    pins(w_nxt_state, w_nxt_q, w_nxt_bit, w_tx, w_nxt_left == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_q           <= 2'd0;
      r_bit         <= 4'd0;
      r_qcnt        <= '0;
      r_left        <= 4'd0;
      r_rw          <= 1'b0;
      r_dev         <= 7'd0;
      r_reg         <= 8'd0;
      r_wdata       <= 8'd0;
      r_shift       <= 7'd0;
      r_nack        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ack_err     <= 1'b0;
      r_rdata       <= 8'd0;
      r_rdata_valid <= 1'b0;
      r_scl_lo      <= 1'b0;
      r_sda_lo      <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_q           <= w_nxt_q;
      r_bit         <= w_nxt_bit;
      r_qcnt        <= w_nxt_qcnt;
      r_left        <= w_nxt_left;
      r_rw          <= w_nxt_rw;
      r_dev         <= w_nxt_dev;
      r_reg         <= w_nxt_reg;
      r_wdata       <= w_nxt_wdata;
      r_shift       <= w_nxt_shift;
      r_nack        <= w_nxt_nack;
      r_busy        <= w_nxt_busy;
      r_done        <= w_nxt_done;
      r_ack_err     <= w_nxt_ack_err;
      r_rdata       <= w_nxt_rdata;
      r_rdata_valid <= w_nxt_rdata_valid;
      r_scl_lo      <= w_nxt_scl_lo;
      r_sda_lo      <= w_nxt_sda_lo;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign ack_err     = r_ack_err;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign scl_drv_lo  = r_scl_lo;
  assign sda_drv_lo  = r_sda_lo;

endmodule

// File: tb/tb_jml_i2c_master.sv
// Bench for jml_i2c_master: bus-level target model at address 7'h10 with a
// scoreboard of expected bus bytes, read bytes and controller ACK bits.
module tb_jml_i2c_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BITP    = 4 * CLK_DIV;
  localparam logic [6:0]  MODEL_ADDR = 7'h10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic [3:0] nbytes = 4'd0;
  logic       busy, done, ack_err, rdata_valid;
  logic [7:0] rdata;
  logic       scl_in, sda_in, scl_drv_lo, sda_drv_lo;
  logic       m_scl_lo = 1'b0;
  logic       m_sda_lo = 1'b0;

  always #5 clk = ~clk;

  assign scl_in = !(scl_drv_lo || m_scl_lo);
  assign sda_in = !(sda_drv_lo || m_sda_lo);

  jml_i2c_master #(.CLK_DIV(CLK_DIV), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .nbytes(nbytes), .busy(busy), .done(done),
    .ack_err(ack_err), .rdata(rdata), .rdata_valid(rdata_valid), .scl_in(scl_in),
    .sda_in(sda_in), .scl_drv_lo(scl_drv_lo), .sda_drv_lo(sda_drv_lo)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [7:0] rd_src[$];
  logic       exp_mack[$];

  // Target model state
  int         t_bit = -1;
  int         t_mode = 0;   // 0 idle, 1 address, 2 write data, 3 read data
  int         t_nb = 0;
  int         t_str = 0;
  logic       t_rd = 1'b0;
  logic       t_ack = 1'b0;
  logic       t_mnack = 1'b0;
  logic [7:0] t_sh = 8'd0;
  logic [7:0] t_tx = 8'd0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  logic       stretch_en = 1'b0;
  int         n_rise = 0;
  int         n_start = 0;
  int         n_stop = 0;

  always @(negedge clk) begin : target_model
    if (reset) begin
      t_mode = 0; t_bit = -1; m_scl_lo = 1'b0; m_sda_lo = 1'b0;
      p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      if (p_scl && scl_in && p_sda && !sda_in) begin
        n_start++;
        t_mode = 1; t_bit = -1; t_rd = 1'b0; t_nb = 0; m_sda_lo = 1'b0;
      end else if (p_scl && scl_in && !p_sda && sda_in) begin
        n_stop++;
        t_mode = 0; m_sda_lo = 1'b0;
      end else if (!p_scl && scl_in) begin
        n_rise++;
        if (t_bit >= 0 && t_bit < 8 && (t_mode == 1 || t_mode == 2)) begin
          t_sh = {t_sh[6:0], sda_in};
        end else if (t_bit == 8 && t_mode == 3) begin
          t_mnack = sda_in;
          if (exp_mack.size() == 0) check_eq("ctrl_ack_unexpected", 32'd1, 32'd0);
          else check_eq("ctrl_ack_bit", 32'(sda_in), 32'(exp_mack.pop_front()));
        end
      end else if (p_scl && !scl_in && t_mode != 0) begin
        if (t_bit == 7) begin
          t_bit = 8;
          if (t_mode == 3) begin
            m_sda_lo = 1'b0;
          end else begin
            if (exp_bus.size() == 0) check_eq("bus_byte_unexpected", 32'(t_sh), 32'hFFFF);
            else check_eq("bus_byte", 32'(t_sh), 32'(exp_bus.pop_front()));
            if (t_mode == 1) begin
              t_ack = (t_sh[7:1] == MODEL_ADDR);
              t_rd  = t_sh[0];
            end else begin
              t_ack = 1'b1;
            end
            m_sda_lo = t_ack;
            if (t_mode == 2 && t_nb == 0 && stretch_en) begin
              m_scl_lo = 1'b1; t_str = 0;
            end
            if (t_mode == 2) t_nb++;
            if (!t_ack) t_mode = 0;
          end
        end else if (t_bit == 8) begin
          t_bit = 0;
          if ((t_mode == 1 && t_rd) || (t_mode == 3 && !t_mnack)) begin
            t_mode = 3;
            t_tx = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hEE;
            m_sda_lo = !t_tx[7];
          end else if (t_mode == 3) begin
            t_mode = 0; m_sda_lo = 1'b0;
          end else begin
            t_mode = 2; m_sda_lo = 1'b0;
          end
        end else begin
          t_bit++;
          if (t_mode == 3) m_sda_lo = !t_tx[3'(7 - t_bit)];
        end
      end
      p_scl = scl_in;
      p_sda = sda_in;
      // Hold SCL low for 37 clocks once the controller has let go of it.
      if (m_scl_lo && !scl_drv_lo) begin
        t_str++;
        if (t_str >= 37) m_scl_lo = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : rdata_mon
    if (!reset && rdata_valid) begin
      if (exp_rd.size() == 0) check_eq("rdata_unexpected", 32'(rdata), 32'hFFFF);
      else check_eq("rdata", 32'(rdata), 32'(exp_rd.pop_front()));
    end
  end

  task automatic run_txn(input string name, input logic i_rw, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd, input logic [3:0] nb,
                         input int exp_lat, input int tol, input logic exp_err,
                         input int exp_rises, input int exp_starts);
    int r0, s0, p0, lat;
    bit seen;
    r0 = n_rise; s0 = n_start; p0 = n_stop;
    rw = i_rw; dev_addr = dev; reg_addr = ra; wdata = wd; nbytes = nb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({name, "_busy_rise"}, 32'(busy), 32'd1);
    check_eq({name, "_no_early_done"}, 32'(done), 32'd0);
    lat = 0; seen = 0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (done) seen = 1;
    end
    if (!seen) begin
      check_eq({name, "_done_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({name, "_latency"},
             32'((lat >= exp_lat - tol && lat <= exp_lat + tol) ? exp_lat : lat),
             32'(exp_lat));
    check_eq({name, "_ack_err"}, 32'(ack_err), 32'(exp_err));
    check_eq({name, "_busy_at_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    check_eq({name, "_busy_drop"}, 32'(busy), 32'd0);
    check_eq({name, "_done_pulse"}, 32'(done), 32'd0);
    check_eq({name, "_ack_err_hold"}, 32'(ack_err), 32'(exp_err));
    check_eq({name, "_bus_released"}, 32'({scl_drv_lo, sda_drv_lo}), 32'd0);
    check_eq({name, "_scl_rises"}, 32'(n_rise - r0), 32'(exp_rises));
    check_eq({name, "_starts"}, 32'(n_start - s0), 32'(exp_starts));
    check_eq({name, "_stops"}, 32'(n_stop - p0), 32'd1);
    check_eq({name, "_bus_q_left"}, 32'(exp_bus.size()), 32'd0);
    check_eq({name, "_rd_q_left"}, 32'(exp_rd.size()), 32'd0);
    check_eq({name, "_mack_q_left"}, 32'(exp_mack.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic intrude();
    repeat (100) @(negedge clk);
    check_eq("intrude_busy", 32'(busy), 32'd1);
    rw = 1'b1; dev_addr = 7'h55; reg_addr = 8'h77; wdata = 8'h99; nbytes = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n_done;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ack_err", 32'(ack_err), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    check_eq("rst_drv", 32'({scl_drv_lo, sda_drv_lo}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain write
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h05); exp_bus.push_back(8'hA5);
    run_txn("wr", 1'b0, 7'h10, 8'h05, 8'hA5, 4'd0, 116 * CLK_DIV, 0, 1'b0, 28, 1);

    // Read of three bytes
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h02); exp_bus.push_back(8'h21);
    rd_src.push_back(8'h11); rd_src.push_back(8'h22); rd_src.push_back(8'h33);
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22); exp_rd.push_back(8'h33);
    exp_mack.push_back(1'b0); exp_mack.push_back(1'b0); exp_mack.push_back(1'b1);
    run_txn("rd3", 1'b1, 7'h10, 8'h02, 8'h00, 4'd3, (30 + 27) * BITP, 0, 1'b0, 56, 2);
    check_eq("rd3_rdata_hold", 32'(rdata), 32'h33);

    // nbytes=0 reads a single byte
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h07); exp_bus.push_back(8'h21);
    rd_src.push_back(8'h5E); exp_rd.push_back(8'h5E); exp_mack.push_back(1'b1);
    run_txn("rd0", 1'b1, 7'h10, 8'h07, 8'h00, 4'd0, (30 + 9) * BITP, 0, 1'b0, 38, 2);

    // Wrong address: NACK then STOP
    exp_bus.push_back(8'h22);
    run_txn("nack", 1'b0, 7'h11, 8'h05, 8'hA5, 4'd0, 11 * BITP, 0, 1'b1, 10, 1);

    // Clock stretch on the register byte ACK
    stretch_en = 1'b1;
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h05); exp_bus.push_back(8'h3C);
    run_txn("stretch", 1'b0, 7'h10, 8'h05, 8'h3C, 4'd0, 116 * CLK_DIV + 37, CLK_DIV,
            1'b0, 28, 1);
    stretch_en = 1'b0;

    // Reset in the middle of the register byte
    exp_bus.push_back(8'h20);
    rw = 1'b0; dev_addr = 7'h10; reg_addr = 8'h05; wdata = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (196) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_drv", 32'({scl_drv_lo, sda_drv_lo}), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("midrst_no_done", 32'(n_done), 32'd0);
    check_eq("midrst_bus_q", 32'(exp_bus.size()), 32'd0);
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h05); exp_bus.push_back(8'h5A);
    run_txn("postrst", 1'b0, 7'h10, 8'h05, 8'h5A, 4'd0, 116 * CLK_DIV, 0, 1'b0, 28, 1);

    // Start while busy is ignored
    exp_bus.push_back(8'h20); exp_bus.push_back(8'h33); exp_bus.push_back(8'h5C);
    fork
      run_txn("busystart", 1'b0, 7'h10, 8'h33, 8'h5C, 4'd0, 116 * CLK_DIV, 0, 1'b0, 28, 1);
      intrude();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jml_i2c_master.md
Name: jml_i2c_master

Overview:
- I2C controller (initiator) that drives register-bridge transactions to on-board I2C targets, including the FPGA's own target-side register bridge.
- Firmware-side logic supplies the device address, register address and write data, or a read byte count.
- The block generates START, repeated START, STOP, address/data bytes and ACK/NACK on open-drain SCL/SDA, and returns read bytes one at a time.
- Single system clock; SCL timing is derived from a quarter-period tick.

Parameters:
- CLK_DIV, 125, system clocks per SCL quarter-period (minimum 2); SCL period = 4*CLK_DIV clocks.
- CNT_W, 8, width of the quarter-tick counter; must hold CLK_DIV-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only when busy=0
- rw  input  1  1=read, 0=write; captured with start
- dev_addr  input  7  target address; captured with start
- reg_addr  input  8  register address byte; captured with start
- wdata  input  8  write data byte; captured with start
- nbytes  input  4  read byte count, 1-15 (0 is treated as 1); captured with start
- busy  output  1  transaction in progress
- done  output  1  one-cycle pulse at end of transaction
- ack_err  output  1  set with done if any target ACK slot saw NACK; held until next start
- rdata  output  8  received byte; valid when rdata_valid=1, holds between pulses
- rdata_valid  output  1  one-cycle pulse per received byte
- scl_in  input  1  SCL pin level
- sda_in  input  1  SDA pin level
- scl_drv_lo  output  1  1 = pull SCL low
- sda_drv_lo  output  1  1 = pull SDA low

Behaviour:
- Reset: all outputs 0, FSM IDLE, bus released (both drv_lo=0); this also holds on reset mid-transfer (no STOP issued).
- Quarter tick: counter runs only while busy. The tick fires every CLK_DIV clocks; each bit period is quarters Q0..Q3.
- Data bit timing:
  - Q0: SCL low; SDA updated.
  - Q1: SCL low.
  - Q2: SCL released.
  - Q3: SCL high; SDA sampled at end of Q3.
- Clock stretching: after SCL is released, Q2 does not advance until scl_in=1.
- START (4 quarters): SDA released, SCL released → pull SDA low at Q2 → pull SCL low at end of Q3.
- Repeated START: release SDA while SCL low (Q0), release SCL (Q1), pull SDA low (Q2), pull SCL low (Q3).
- STOP: SDA low with SCL low (Q0), release SCL (Q1), release SDA (Q2), Q3 idle → done pulse, busy drops the following cycle.
- Bytes are sent MSB first. Ninth bit:
  - Controller releases SDA during target-ACK slots and samples it at Q3; sda_in=1 means NACK.
  - On a NACK, ack_err is set, the rest of the transaction is skipped and the FSM goes to STOP.
- FSM states: IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDATA, STOP.
- Write sequence: START, DEVW ({dev_addr,0}), REG, WDATA, STOP = 29 bit periods (116*CLK_DIV clocks with no stretching).
- Read sequence: START, DEVW, REG, RSTART, DEVR ({dev_addr,1}), then nbytes × RDATA, then STOP.
  - Length: 30+9*nbytes bit periods.
  - Controller ACKs (drives SDA low) every read byte except the last, which it NACKs.
  - rdata_valid pulses on the clock after bit 0 of each byte is sampled.
- start while busy: ignored, with no effect on captured fields.
- Bus arbitration and multi-master operation are not supported. No sda_in check is made while the controller is driving.
- busy rises the cycle after an accepted start. done and busy=0 are never asserted in the same cycle as start acceptance.

Test Plan:
- Write: dev 7'h10, reg 8'h05, wdata 8'hA5, CLK_DIV=4, ACKing target model → bytes 8'h20, 8'h05, 8'hA5 on the bus, START/STOP legal; done after 464 clocks; ack_err=0.
- Read 3 from reg 8'h02, model returns 8'h11, 8'h22, 8'h33 → bytes 8'h20, 8'h02, then Sr, then 8'h21; rdata_valid ×3 with 8'h11/22/33; controller ACK, ACK, NACK; then STOP; done, ack_err=0.
- Wrong address 7'h11, model NACKs → STOP immediately after the first ACK slot; done with ack_err=1; no further SCL pulses.
- Clock stretch: model holds SCL low 37 clocks on the ACK of the reg byte → high phase starts only after release; data intact; total latency +37 clocks (±CLK_DIV).
- Reset asserted mid-REG byte → the next cycle shows both drv_lo=0, busy=0, no done; a new write after reset completes correctly.
- start pulsed while busy with rw=1 and different addresses → ignored; the original write completes unchanged.
